// File: rtl/ascon_perm_round_ctrl.sv
// Ascon permutation round controller: holds the 320-bit state and
// steps it through an external round datapath, one pass per clock.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready/in_state/in_mode   job input handshake
//   out_valid/out_ready/out_state        result handshake
//   rnd_en/rnd_state_o/rnd_state_i/rc0/rc1   round datapath link
//   busy              job in flight (RUN or DONE)
//   perf_cycles       RUN-cycle counter, only with ASCON_PERM_CYCLE_CNT_EN
module ascon_perm_round_ctrl #(
  parameter int UNROLL = 1,
  parameter int RC_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [319:0]    in_state,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [319:0]    out_state,
  output logic            rnd_en,
  output logic [319:0]    rnd_state_o,
  input  logic [319:0]    rnd_state_i,
  output logic [RC_W-1:0] rc0,
  output logic [RC_W-1:0] rc1,
`ifdef ASCON_PERM_CYCLE_CNT_EN
  output logic [15:0]     perf_cycles,
`endif
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } st_t;

  localparam logic [3:0] STEP = 4'(UNROLL);
  localparam logic [3:0] LAST = 4'(12 - UNROLL);

  st_t          st;
  logic [319:0] state_reg;
  logic [3:0]   ridx;
  logic [3:0]   start_idx;

  // Shorter permutations run the tail of the 12-round schedule.
  always_comb begin
    start_idx = 4'd0;
    unique case (1'b1)
      (in_mode == 2'b01): start_idx = 4'd4;
      (in_mode == 2'b10): start_idx = 4'd6;
      default:            start_idx = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      state_reg <= '0;
      ridx      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rnd_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            state_reg <= in_state;
            ridx      <= start_idx;
            st        <= RUN;
            in_ready  <= 1'b0;
            rnd_en    <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          state_reg <= rnd_state_i;
          ridx      <= ridx + STEP;
          if (ridx == LAST) begin
            st        <= DONE;
            rnd_en    <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          st        <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          rnd_en    <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASCON_PERM_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      perf_cycles <= '0;
    else if (st == RUN && perf_cycles != 16'hFFFF)
      perf_cycles <= perf_cycles + 16'd1;
  end
`endif

  // Datapath inputs are zeroed outside RUN so it sees no toggling.
  assign rnd_state_o = rnd_en ? state_reg : '0;
  assign out_state   = out_valid ? state_reg : '0;
  assign rc0 = rnd_en ? {4'hF - ridx, ridx} : '0;

  generate
    if (UNROLL == 2) begin : g_pair
      logic [3:0] ridx1;
      assign ridx1 = ridx + 4'd1;
      assign rc1 = rnd_en ? {4'hF - ridx1, ridx1} : '0;
    end else begin : g_single
      assign rc1 = '0;
    end
  endgenerate

endmodule
